// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin serial-bus arbiter: FSM encodings and width helpers.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGrant   = 3'd1,
        StAddr    = 3'd2,
        StConnect = 3'd3,
        StBusy    = 3'd4,
        StErr     = 3'd5
    } arb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A disabled timeout still needs a one-bit counter to keep the port widths legal.
    function automatic int unsigned to_w(input int unsigned t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bit-serial master/slave bus bundle seen by the arbiter, with per-role modports.
interface bus_arbiter_rr_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3
);

    logic [NUM_MASTERS-1:0] m_request;
    logic [NUM_MASTERS-1:0] m_address_valid;
    logic [NUM_MASTERS-1:0] m_valid;
    logic [NUM_MASTERS-1:0] m_address;
    logic [NUM_MASTERS-1:0] m_data;
    logic [NUM_MASTERS-1:0] m_write_en;
    logic [NUM_MASTERS-1:0] m_burst;

    logic [NUM_SLAVES-1:0]  s_ready;
    logic [NUM_SLAVES-1:0]  s_data_in;
    logic [NUM_SLAVES-1:0]  s_valid_out;

    logic [NUM_MASTERS-1:0] m_available;
    logic [NUM_MASTERS-1:0] m_grant;
    logic [NUM_MASTERS-1:0] m_ready;
    logic [NUM_MASTERS-1:0] m_data_out;
    logic [NUM_MASTERS-1:0] m_valid_in;
    logic [NUM_MASTERS-1:0] m_decode_err;

    logic [NUM_SLAVES-1:0]  s_address;
    logic [NUM_SLAVES-1:0]  s_data;
    logic [NUM_SLAVES-1:0]  s_valid;
    logic [NUM_SLAVES-1:0]  s_write_en;
    logic [NUM_SLAVES-1:0]  s_burst;

    logic [2:0]             state;

    modport arb (
        input  m_request, m_address_valid, m_valid, m_address, m_data, m_write_en, m_burst,
        input  s_ready, s_data_in, s_valid_out,
        output m_available, m_grant, m_ready, m_data_out, m_valid_in, m_decode_err,
        output s_address, s_data, s_valid, s_write_en, s_burst,
        output state
    );

    modport master (
        output m_request, m_address_valid, m_valid, m_address, m_data, m_write_en, m_burst,
        input  m_available, m_grant, m_ready, m_data_out, m_valid_in, m_decode_err
    );

    modport slave (
        input  s_address, s_data, s_valid, s_write_en, s_burst,
        output s_ready, s_data_in, s_valid_out
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after the pointer, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic                   o_found,
    output logic [IDX_W-1:0]       o_idx
);

    always_comb begin
        int unsigned w_cand;
        w_cand  = 0;
        o_found = 1'b0;
        o_idx   = '0;
        // Walk from farthest to nearest so the closest candidate after the pointer wins.
        for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = (32'(i_ptr) + k) % NUM_MASTERS;
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for bit-serial masters: serial slave select, routing, decode error, timeout.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned SEL_BITS    = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_rr_if.arb bus
);

    localparam int unsigned IDX_W = idx_w(NUM_MASTERS);
    localparam int unsigned TO_W  = to_w(TIMEOUT);
    localparam int unsigned CNT_W = $clog2(SEL_BITS + 1);
    localparam int unsigned SEL_W1 = SEL_BITS + 1;

    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SEL_BITS);
    localparam logic [SEL_W1-1:0] SLV_LIMIT = SEL_W1'(NUM_SLAVES);

    arb_state_e            r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_owner, w_owner_nxt;
    logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [SEL_BITS-1:0]   r_sel, w_sel_nxt;
    logic [TO_W-1:0]       r_to, w_to_nxt;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic                   w_found;
    logic [IDX_W-1:0]       w_win;

    logic w_own_req, w_own_av, w_own_valid, w_own_addr;
    logic w_own_data, w_own_we, w_own_burst;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [TO_W-1:0]  w_to_inc;

    assign w_eligible  = bus.m_request & bus.m_address_valid;
    assign w_own_req   = bus.m_request[r_owner];
    assign w_own_av    = bus.m_address_valid[r_owner];
    assign w_own_valid = bus.m_valid[r_owner];
    assign w_own_addr  = bus.m_address[r_owner];
    assign w_own_data  = bus.m_data[r_owner];
    assign w_own_we    = bus.m_write_en[r_owner];
    assign w_own_burst = bus.m_burst[r_owner];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_to_inc    = r_to + TO_W'(1);

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_to_nxt    = '0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt = StGrant;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = w_win;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = '0;
                end
            end
            StGrant, StAddr: begin
                if (w_own_valid) begin
                    w_sel_nxt   = SEL_BITS'({r_sel, w_own_addr});
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc == CNT_LAST) ? StConnect : StAddr;
                end
            end
            StConnect: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ({1'b0, r_sel} < SLV_LIMIT) ? StBusy : StErr;
            end
            StBusy: begin
                if (w_own_av) begin
                    w_state_nxt = StGrant;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = '0;
                end else if (!w_own_valid) begin
                    w_to_nxt = w_to_inc;
                    if ((TIMEOUT != 0) && (w_to_inc == TO_MAX)) begin
                        w_state_nxt = StIdle;
                        w_to_nxt    = '0;
                    end
                end
            end
            StErr:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        // Losing the owner's request outranks every other transition.
        if ((r_state != StIdle) && !w_own_req) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_to_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_ptr   <= IDX_W'(NUM_MASTERS - 1);
            r_cnt   <= '0;
            r_sel   <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_to    <= w_to_nxt;
        end
    end

    logic [NUM_MASTERS-1:0] w_own_vec;
    logic [NUM_SLAVES-1:0]  w_sel_vec, w_route_vec;
    logic                   w_route, w_in_grant;

    always_comb begin
        w_own_vec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_own_vec[i] = (r_owner == IDX_W'(i));
        end
        w_sel_vec = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            w_sel_vec[j] = (r_sel == SEL_BITS'(j));
        end
    end

    assign w_route     = (r_state == StBusy);
    assign w_in_grant  = (r_state inside {StGrant, StAddr, StConnect, StBusy});
    assign w_route_vec = w_route ? w_sel_vec : '0;

    assign bus.m_available  = (r_state == StIdle) ? '1 : w_own_vec;
    assign bus.m_grant      = w_in_grant ? w_own_vec : '0;
    assign bus.m_decode_err = ((r_state == StErr) && w_own_req) ? w_own_vec : '0;

    assign bus.s_address  = w_route_vec & {NUM_SLAVES{w_own_addr}};
    assign bus.s_data     = w_route_vec & {NUM_SLAVES{w_own_data}};
    assign bus.s_valid    = w_route_vec & {NUM_SLAVES{w_own_valid}};
    assign bus.s_write_en = w_route_vec & {NUM_SLAVES{w_own_we}};
    assign bus.s_burst    = w_route_vec & {NUM_SLAVES{w_own_burst}};

    assign bus.m_ready    = (|(bus.s_ready & w_route_vec))     ? w_own_vec : '0;
    assign bus.m_data_out = (|(bus.s_data_in & w_route_vec))   ? w_own_vec : '0;
    assign bus.m_valid_in = (|(bus.s_valid_out & w_route_vec)) ? w_own_vec : '0;

    assign bus.state = r_state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus random traffic vs. a behavioural model.
module tb_bus_arbiter_rr;

    localparam int N  = 2;
    localparam int M  = 3;
    localparam int SB = 2;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    bus_arbiter_rr_if #(.NUM_MASTERS(N), .NUM_SLAVES(M)) bif ();

    bus_arbiter_rr #(
        .NUM_MASTERS (N),
        .NUM_SLAVES  (M),
        .SEL_BITS    (SB),
        .TIMEOUT     (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase number, owner, rr pointer, collected address, bits, idle run.
    int md_state, md_owner, md_ptr, md_addr, md_nbits, md_idle;

    logic [2:0]     exp_state;
    logic [N-1:0]   exp_grant, exp_avail, exp_err;
    logic [5*M-1:0] exp_s;
    logic [3*N-1:0] exp_m;

    task automatic model_edge();
        int nstate;
        int c;
        bit found;
        if (reset) begin
            md_state = 0; md_owner = 0; md_ptr = N - 1;
            md_addr = 0; md_nbits = 0; md_idle = 0;
            return;
        end
        nstate = md_state;
        case (md_state)
            0: begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (md_ptr + k) % N;
                    if (!found && bif.m_request[c] && bif.m_address_valid[c]) begin
                        found = 1; md_owner = c; md_ptr = c;
                        md_addr = 0; md_nbits = 0; nstate = 1;
                    end
                end
            end
            1, 2: begin
                if (bif.m_valid[md_owner]) begin
                    md_addr  = md_addr * 2 + int'(bif.m_address[md_owner]);
                    md_nbits = md_nbits + 1;
                    nstate   = (md_nbits == SB) ? 3 : 2;
                end
            end
            3: begin
                nstate  = (md_addr < M) ? 4 : 5;
                md_idle = 0;
            end
            4: begin
                if (bif.m_address_valid[md_owner]) begin
                    nstate = 1; md_addr = 0; md_nbits = 0; md_idle = 0;
                end else if (bif.m_valid[md_owner]) begin
                    md_idle = 0;
                end else begin
                    md_idle = md_idle + 1;
                    if (TO > 0 && md_idle == TO) begin
                        nstate = 0; md_idle = 0;
                    end
                end
            end
            default: nstate = 0;
        endcase
        if (md_state != 0 && !bif.m_request[md_owner]) begin
            nstate = 0; md_idle = 0;
        end
        md_state = nstate;
    endtask

    task automatic model_outputs();
        logic [M-1:0] sa, sd, sv, sw, sb;
        logic [N-1:0] mr, md, mv;
        exp_state = 3'(md_state);
        exp_grant = '0; exp_err = '0;
        exp_avail = '1;
        sa = '0; sd = '0; sv = '0; sw = '0; sb = '0;
        mr = '0; md = '0; mv = '0;
        if (md_state >= 1 && md_state <= 4) exp_grant[md_owner] = 1'b1;
        if (md_state != 0) begin
            exp_avail = '0;
            exp_avail[md_owner] = 1'b1;
        end
        if (md_state == 5 && bif.m_request[md_owner]) exp_err[md_owner] = 1'b1;
        if (md_state == 4) begin
            sa[md_addr] = bif.m_address[md_owner];
            sd[md_addr] = bif.m_data[md_owner];
            sv[md_addr] = bif.m_valid[md_owner];
            sw[md_addr] = bif.m_write_en[md_owner];
            sb[md_addr] = bif.m_burst[md_owner];
            mr[md_owner] = bif.s_ready[md_addr];
            md[md_owner] = bif.s_data_in[md_addr];
            mv[md_owner] = bif.s_valid_out[md_addr];
        end
        exp_s = {sa, sd, sv, sw, sb};
        exp_m = {mr, md, mv};
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bif.m_request = '0; bif.m_address_valid = '0; bif.m_valid = '0;
        bif.m_address = '0; bif.m_data = '0; bif.m_write_en = '0; bif.m_burst = '0;
        bif.s_ready = '0; bif.s_data_in = '0; bif.s_valid_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bif.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bif.state); end
        n_cmp++; if (bif.m_grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", bif.m_grant); end
        n_cmp++; if (bif.m_available !== 2'b11) begin n_bad++; $display("FAIL reset_avail: got %b want 11", bif.m_available); end
        n_cmp++; if (bif.m_decode_err !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", bif.m_decode_err); end
        n_cmp++; if (bif.s_valid !== 3'b000) begin n_bad++; $display("FAIL reset_svalid: got %b want 000", bif.s_valid); end
    endtask

    task automatic test_single_master();
        do_reset();
        bif.m_request = 2'b01; bif.m_address_valid = 2'b01;
        tick();
        n_cmp++; if (bif.state !== 3'd1) begin n_bad++; $display("FAIL single_grant_state: got %0d want 1", bif.state); end
        n_cmp++; if (bif.m_available !== 2'b01) begin n_bad++; $display("FAIL single_avail: got %b want 01", bif.m_available); end
        bif.m_address_valid = 2'b00; bif.m_valid = 2'b01; bif.m_address = 2'b00;
        tick();
        n_cmp++; if (bif.state !== 3'd2) begin n_bad++; $display("FAIL single_addr_state: got %0d want 2", bif.state); end
        bif.m_address = 2'b01;
        tick();
        n_cmp++; if (bif.state !== 3'd3) begin n_bad++; $display("FAIL single_conn_state: got %0d want 3", bif.state); end
        n_cmp++; if (bif.s_valid !== 3'b000) begin n_bad++; $display("FAIL single_conn_svalid: got %b want 000", bif.s_valid); end
        tick();
        n_cmp++; if (bif.state !== 3'd4) begin n_bad++; $display("FAIL single_busy_state: got %0d want 4", bif.state); end
        bif.m_address = 2'b00; bif.m_data = 2'b01; bif.m_write_en = 2'b01; bif.s_ready = 3'b010;
        #1;
        n_cmp++; if (bif.s_valid !== 3'b010) begin n_bad++; $display("FAIL single_svalid: got %b want 010", bif.s_valid); end
        n_cmp++; if ({bif.s_data, bif.s_write_en, bif.s_burst} !== 9'b010_010_000) begin
            n_bad++; $display("FAIL single_route: got %b want 010010000", {bif.s_data, bif.s_write_en, bif.s_burst}); end
        n_cmp++; if (bif.m_ready !== 2'b01) begin n_bad++; $display("FAIL single_mready: got %b want 01", bif.m_ready); end
        n_cmp++; if (bif.m_available !== 2'b01) begin n_bad++; $display("FAIL single_busy_avail: got %b want 01", bif.m_available); end
        bif.m_valid = 2'b00;
        #1;
        n_cmp++; if (bif.s_valid !== 3'b000) begin n_bad++; $display("FAIL single_svalid_low: got %b want 000", bif.s_valid); end
        tick();
        bif.m_request = 2'b00;
        tick();
        n_cmp++; if (bif.state !== 3'd0) begin n_bad++; $display("FAIL single_release: got %0d want 0", bif.state); end
        drive_idle();
    endtask

    task automatic test_round_robin();
        int exp_own;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            exp_own = t % 2;
            bif.m_request = 2'b11; bif.m_address_valid = 2'b11; bif.m_valid = 2'b00;
            tick();
            n_cmp++; if (bif.m_grant !== 2'(1 << exp_own)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", t, bif.m_grant, 2'(1 << exp_own)); end
            bif.m_address_valid = 2'b00; bif.m_valid = 2'(1 << exp_own); bif.m_address = 2'b00;
            tick(); tick(); tick();
            n_cmp++; if (bif.s_valid !== 3'b001) begin n_bad++; $display("FAIL rr_route[%0d]: got %b want 001", t, bif.s_valid); end
            bif.m_request[exp_own] = 1'b0;
            tick();
            n_cmp++; if (bif.state !== 3'd0) begin n_bad++; $display("FAIL rr_release[%0d]: got %0d want 0", t, bif.state); end
        end
        drive_idle();
    endtask

    task automatic test_decode_err();
        do_reset();
        bif.m_request = 2'b10; bif.m_address_valid = 2'b10;
        tick();
        n_cmp++; if (bif.m_grant !== 2'b10) begin n_bad++; $display("FAIL derr_grant: got %b want 10", bif.m_grant); end
        bif.m_address_valid = 2'b00; bif.m_valid = 2'b10; bif.m_address = 2'b10;
        tick(); tick();
        n_cmp++; if (bif.state !== 3'd3) begin n_bad++; $display("FAIL derr_conn: got %0d want 3", bif.state); end
        tick();
        n_cmp++; if (bif.state !== 3'd5) begin n_bad++; $display("FAIL derr_state: got %0d want 5", bif.state); end
        n_cmp++; if (bif.m_decode_err !== 2'b10) begin n_bad++; $display("FAIL derr_pulse: got %b want 10", bif.m_decode_err); end
        n_cmp++; if (bif.s_valid !== 3'b000) begin n_bad++; $display("FAIL derr_svalid: got %b want 000", bif.s_valid); end
        tick();
        n_cmp++; if (bif.state !== 3'd0) begin n_bad++; $display("FAIL derr_idle: got %0d want 0", bif.state); end
        n_cmp++; if (bif.m_decode_err !== 2'b00) begin n_bad++; $display("FAIL derr_pulse_end: got %b want 00", bif.m_decode_err); end
        drive_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        bif.m_request = 2'b01; bif.m_address_valid = 2'b01;
        tick();
        bif.m_address_valid = 2'b00; bif.m_valid = 2'b01; bif.m_address = 2'b00;
        tick();
        bif.m_address = 2'b01;
        tick();
        bif.m_valid = 2'b00;
        tick();
        for (int k = 0; k < TO; k++) begin
            n_cmp++; if (bif.state !== 3'd4) begin n_bad++; $display("FAIL to_busy[%0d]: got %0d want 4", k, bif.state); end
            tick();
        end
        n_cmp++; if (bif.state !== 3'd0) begin n_bad++; $display("FAIL to_release: got %0d want 0", bif.state); end
        n_cmp++; if (bif.m_grant !== 2'b00) begin n_bad++; $display("FAIL to_grant: got %b want 00", bif.m_grant); end
        drive_idle();
    endtask

    task automatic test_readdress();
        do_reset();
        bif.m_request = 2'b11; bif.m_address_valid = 2'b01;
        tick();
        bif.m_address_valid = 2'b10; bif.m_valid = 2'b01; bif.m_address = 2'b00;
        tick();
        bif.m_address = 2'b01;
        tick(); tick();
        n_cmp++; if (bif.s_valid !== 3'b010) begin n_bad++; $display("FAIL readdr_first: got %b want 010", bif.s_valid); end
        bif.m_address_valid = 2'b11;
        tick();
        n_cmp++; if (bif.state !== 3'd1 || bif.s_valid !== 3'b000) begin
            n_bad++; $display("FAIL readdr_regrant: got state %0d sv %b want 1/000", bif.state, bif.s_valid); end
        bif.m_address_valid = 2'b10; bif.m_address = 2'b00;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bif.m_grant !== 2'b01) begin n_bad++; $display("FAIL readdr_hold[%0d]: got %b want 01", k, bif.m_grant); end
            tick();
        end
        n_cmp++; if (bif.s_valid !== 3'b001) begin n_bad++; $display("FAIL readdr_second: got %b want 001", bif.s_valid); end
        drive_idle();
    endtask

    task automatic test_drop_and_reset();
        do_reset();
        bif.m_request = 2'b01; bif.m_address_valid = 2'b01;
        tick();
        bif.m_address_valid = 2'b00; bif.m_valid = 2'b01; bif.m_address = 2'b00;
        tick();
        n_cmp++; if (bif.state !== 3'd2) begin n_bad++; $display("FAIL drop_addr: got %0d want 2", bif.state); end
        bif.m_request = 2'b00;
        tick();
        n_cmp++; if (bif.state !== 3'd0 || bif.m_decode_err !== 2'b00) begin
            n_bad++; $display("FAIL drop_idle: got state %0d err %b want 0/00", bif.state, bif.m_decode_err); end
        bif.m_request = 2'b01; bif.m_address_valid = 2'b01;
        tick();
        bif.m_address_valid = 2'b00; bif.m_address = 2'b01;
        tick();
        bif.m_address = 2'b00;
        tick(); tick();
        n_cmp++; if (bif.s_valid !== 3'b100) begin n_bad++; $display("FAIL rst_busy_route: got %b want 100", bif.s_valid); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({bif.state, bif.m_grant, bif.m_available, bif.m_decode_err} !== 9'b000_00_11_00) begin
            n_bad++; $display("FAIL rst_outputs: got %b want 000001100",
                              {bif.state, bif.m_grant, bif.m_available, bif.m_decode_err}); end
        n_cmp++; if ({bif.s_address, bif.s_data, bif.s_valid, bif.s_write_en, bif.s_burst} !== 15'd0) begin
            n_bad++; $display("FAIL rst_route: got %b want 0",
                              {bif.s_address, bif.s_data, bif.s_valid, bif.s_write_en, bif.s_burst}); end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bif.m_request[i] = ~bif.m_request[i];
                bif.m_address_valid[i] = ($urandom_range(0, 5) == 0);
            end
            bif.m_valid     = N'($urandom);
            bif.m_address   = N'($urandom);
            bif.m_data      = N'($urandom);
            bif.m_write_en  = N'($urandom);
            bif.m_burst     = N'($urandom);
            bif.s_ready     = M'($urandom);
            bif.s_data_in   = M'($urandom);
            bif.s_valid_out = M'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            #1;
            model_outputs();
            n_cmp++; if (bif.state !== exp_state) begin
                n_bad++; $display("FAIL rand_state cyc %0d: got %0d want %0d", cyc, bif.state, exp_state); end
            n_cmp++; if (bif.m_grant !== exp_grant) begin
                n_bad++; $display("FAIL rand_grant cyc %0d: got %b want %b", cyc, bif.m_grant, exp_grant); end
            n_cmp++; if (bif.m_available !== exp_avail) begin
                n_bad++; $display("FAIL rand_avail cyc %0d: got %b want %b", cyc, bif.m_available, exp_avail); end
            n_cmp++; if (bif.m_decode_err !== exp_err) begin
                n_bad++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, bif.m_decode_err, exp_err); end
            n_cmp++; if ({bif.s_address, bif.s_data, bif.s_valid, bif.s_write_en, bif.s_burst} !== exp_s) begin
                n_bad++; $display("FAIL rand_slave cyc %0d: got %b want %b", cyc,
                                  {bif.s_address, bif.s_data, bif.s_valid, bif.s_write_en, bif.s_burst}, exp_s); end
            n_cmp++; if ({bif.m_ready, bif.m_data_out, bif.m_valid_in} !== exp_m) begin
                n_bad++; $display("FAIL rand_master cyc %0d: got %b want %b", cyc,
                                  {bif.m_ready, bif.m_data_out, bif.m_valid_in}, exp_m); end
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive_idle();
        md_state = 0; md_owner = 0; md_ptr = N - 1;
        md_addr = 0; md_nbits = 0; md_idle = 0;
        test_reset();
        test_single_master();
        test_round_robin();
        test_decode_err();
        test_timeout();
        test_readdress();
        test_drop_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
